fifo_bank4: RTL and testbench
=============================

// Module: fifo_bank4
// PURPOSE
// - Upstream stage of the per-channel pop counter: a 4-channel FIFO bank that routes incoming words by destination field.
// - Exposes per-channel empty flags and accepts per-channel pops; the counter drives pop0..pop3 and tallies words drained per channel.
// - Provides full/almost-full backpressure (pause) toward the transaction-layer source.
// PARAMETERS
// - DATA_WIDTH  10  word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are destination channel 0..3
// - ADDR_WIDTH   3  pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries per channel
// - AF_THRESH    6  almost_fullN asserted when occupancy of channel N >= AF_THRESH (1..DEPTH)
// PORTS
// - clk                       in   1    single clock, all logic on rising edge
// - reset_L                   in   1    asynchronous, active-low reset
// - push                      in   1    write data_in into channel data_in[MSB:MSB-1]
// - data_in                   in   DW   word incl. destination field
// - pop0..pop3                in   1    read one word from channel N
// - data_out0..data_out3      out  DW   registered read data, channel N
// - valid_out0..valid_out3    out  1    one-cycle pulse: data_outN holds a popped word
// - empty0..empty3            out  1    channel N occupancy == 0
// - full0..full3              out  1    channel N occupancy == DEPTH
// - almost_full0..3           out  1    channel N occupancy >= AF_THRESH
// - pause                     out  1    OR of almost_full0..3
// - err                       out  1    sticky overflow flag (only with OVERFLOW_ERR_EN; else tied 0)
// BEHAVIOUR
// - Reset (async, reset_L=0): all pointers/occupancies 0; empty*=1; full*=0; almost_full*=0; pause=0;
//   data_out*=0; valid_out*=0; err=0. Stored words discarded; reset mid-traffic drops everything.
// - Per channel: circular buffer, wr_ptr/rd_ptr ADDR_WIDTH bits wrap mod DEPTH; occupancy ADDR_WIDTH+1 bits.
// - Push: decoded channel d = data_in[DW-1:DW-2]; if push && !full_d, mem_d[wr_ptr_d] <= data_in (full word
//   kept, dest bits included), wr_ptr_d++, occupancy_d++. Push while full_d: word dropped, no state change
//   (even if pop_d in same cycle; full is evaluated on registered pre-edge state).
// - Pop: if popN && !emptyN: data_outN <= mem_N[rd_ptr_N], valid_outN <= 1 next edge, rd_ptr_N++, occupancy_N--.
//   Pop while empty: ignored, valid_outN <= 0, data_outN holds previous value (counter pops back-to-back
//   from registered empty, so pop-on-empty is normal traffic, not an error).
// - Latency: push at edge t -> emptyN=0 visible after edge t; pop at edge t -> data_outN/valid_outN after edge t.
// - Simultaneous push+pop, same channel, neither full nor empty: both executed, occupancy unchanged.
//   Push+pop on empty channel: push accepted, pop ignored (no fall-through).
// - Channels are independent; push to channel d never alters channels != d.
// - Flags (empty/full/almost_full) combinational from registered occupancy; pause combinational OR.
// - valid_outN is a single-cycle pulse per accepted pop; consecutive pops give consecutive pulses.
// CONFIGURATION
// - OVERFLOW_ERR_EN defined: err set to 1 on the edge after any push with full_d=1; stays 1 until reset_L=0.
// - OVERFLOW_ERR_EN undefined: err tied to 0; overflow pushes still silently dropped.
// TESTING
// - Reset then idle -> empty0..3=1, full0..3=0, pause=0, data_out*=0, valid_out*=0, err=0.
// - Push 0x005,0x10A,0x20F,0x3FF (ch 0..3), pop all next cycle -> data_out0..3=0x005,0x10A,0x20F,0x3FF,
//   valid_out0..3 pulse one cycle, all empty=1 afterwards.
// - Push 9 words to ch2 -> almost_full2=1 and pause=1 after 6th, full2=1 after 8th, 9th dropped;
//   err=1 with OVERFLOW_ERR_EN, 0 without; 8 pops return words 1..8 in order, 9th pop gives no valid pulse.
// - Ch1 holding 3 words: push+pop same cycle for 10 cycles -> occupancy stays 3, FIFO order preserved
//   across pointer wrap, empty1/full1 never toggle.
// - Pop0 asserted every cycle with 1 word pushed -> exactly one valid_out0 pulse, data_out0 unchanged after.
// - 4 words in ch3, reset_L=0 mid-stream for 1 cycle -> empty3=1, pops return no valid, err cleared.

Source files
------------

// File: rtl/fifo_bank4_if.sv
// Bus bundle for fifo_bank4: push side, per-channel pop/read side and the
// status flags. The master modport is the traffic source/sink; the slave
// modport is the FIFO bank itself.
interface fifo_bank4_if #(
   parameter int DATA_WIDTH = 10
);
   logic                  push;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pop0, pop1, pop2, pop3;
   logic [DATA_WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
   logic                  valid_out0, valid_out1, valid_out2, valid_out3;
   logic                  empty0, empty1, empty2, empty3;
   logic                  full0, full1, full2, full3;
   logic                  almost_full0, almost_full1, almost_full2, almost_full3;
   logic                  pause;
   logic                  err;

   modport master (
      output push, data_in, pop0, pop1, pop2, pop3,
      input  data_out0, data_out1, data_out2, data_out3,
      input  valid_out0, valid_out1, valid_out2, valid_out3,
      input  empty0, empty1, empty2, empty3,
      input  full0, full1, full2, full3,
      input  almost_full0, almost_full1, almost_full2, almost_full3,
      input  pause, err
   );

   modport slave (
      input  push, data_in, pop0, pop1, pop2, pop3,
      output data_out0, data_out1, data_out2, data_out3,
      output valid_out0, valid_out1, valid_out2, valid_out3,
      output empty0, empty1, empty2, empty3,
      output full0, full1, full2, full3,
      output almost_full0, almost_full1, almost_full2, almost_full3,
      output pause, err
   );
endinterface

// File: rtl/fifo_bank4.sv
// fifo_bank4: four independent circular FIFOs; incoming words are routed by
// their top two bits. Per-channel pops return registered data with a
// one-cycle valid pulse. Flags derive combinationally from registered
// occupancy, so push-when-full is judged on pre-edge state.
// Optional feature: define OVERFLOW_ERR_EN for a sticky overflow error flag;
// otherwise err is tied low and overflowing words are simply dropped.
module fifo_bank4 #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6
) (
   input  logic            clk,
   input  logic            reset_L,
   fifo_bank4_if.slave     bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int OW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [4][DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q [4], wr_ptr_d [4];
   logic [ADDR_WIDTH-1:0] rd_ptr_q [4], rd_ptr_d [4];
   logic [OW-1:0]         occ_q [4], occ_d [4];
   logic [DATA_WIDTH-1:0] dout_q [4], dout_d [4];
   logic [3:0]            vout_q, vout_d;

   logic [1:0] dest;
   logic [3:0] pop_v, empty_v, full_v, af_v, do_push, do_pop;

   assign dest  = bus.data_in[DATA_WIDTH-1:DATA_WIDTH-2];
   assign pop_v = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

   // status flags from registered occupancy
   always_comb begin
      empty_v = '0;
      full_v  = '0;
      af_v    = '0;
      for (int n = 0; n < 4; n++) begin
         empty_v[n] = (occ_q[n] == '0);
         full_v[n]  = (occ_q[n] == OW'(DEPTH));
         af_v[n]    = (occ_q[n] >= OW'(AF_THRESH));
      end
   end

   // per-channel accept decisions and next-state pointers/occupancy/read data
   always_comb begin
      do_push = '0;
      do_pop  = '0;
      vout_d  = '0;
      for (int n = 0; n < 4; n++) begin
         do_push[n]  = bus.push && (dest == 2'(n)) && !full_v[n];
         do_pop[n]   = pop_v[n] && !empty_v[n];
         wr_ptr_d[n] = wr_ptr_q[n] + ADDR_WIDTH'(do_push[n]);
         rd_ptr_d[n] = rd_ptr_q[n] + ADDR_WIDTH'(do_pop[n]);
         occ_d[n]    = occ_q[n] + OW'(do_push[n]) - OW'(do_pop[n]);
         dout_d[n]   = do_pop[n] ? mem_q[n][rd_ptr_q[n]] : dout_q[n];
         vout_d[n]   = do_pop[n];
      end
   end

   // storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (do_push[n]) mem_q[n][wr_ptr_q[n]] <= bus.data_in;
      end
   end

   // control state registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int n = 0; n < 4; n++) begin
            wr_ptr_q[n] <= '0;
            rd_ptr_q[n] <= '0;
            occ_q[n]    <= '0;
            dout_q[n]   <= '0;
         end
         vout_q <= '0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            wr_ptr_q[n] <= wr_ptr_d[n];
            rd_ptr_q[n] <= rd_ptr_d[n];
            occ_q[n]    <= occ_d[n];
            dout_q[n]   <= dout_d[n];
         end
         vout_q <= vout_d;
      end
   end

`ifdef OVERFLOW_ERR_EN
   logic err_q, err_d;
   assign err_d = err_q | (bus.push & full_v[dest]);

   // sticky overflow flag, cleared only by reset
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.data_out0    = dout_q[0];
   assign bus.data_out1    = dout_q[1];
   assign bus.data_out2    = dout_q[2];
   assign bus.data_out3    = dout_q[3];
   assign bus.valid_out0   = vout_q[0];
   assign bus.valid_out1   = vout_q[1];
   assign bus.valid_out2   = vout_q[2];
   assign bus.valid_out3   = vout_q[3];
   assign bus.empty0       = empty_v[0];
   assign bus.empty1       = empty_v[1];
   assign bus.empty2       = empty_v[2];
   assign bus.empty3       = empty_v[3];
   assign bus.full0        = full_v[0];
   assign bus.full1        = full_v[1];
   assign bus.full2        = full_v[2];
   assign bus.full3        = full_v[3];
   assign bus.almost_full0 = af_v[0];
   assign bus.almost_full1 = af_v[1];
   assign bus.almost_full2 = af_v[2];
   assign bus.almost_full3 = af_v[3];
   assign bus.pause        = |af_v;
endmodule

// File: tb/tb_fifo_bank4.sv
// Testbench for fifo_bank4: a queue-per-channel reference model, an
// expectation queue filled when pops are issued, and a monitor that
// consumes expectations whenever the bank presents read data.
module tb_fifo_bank4;
   localparam int DW    = 10;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
`ifdef OVERFLOW_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_L = 1'b0;

   fifo_bank4_if #(.DATA_WIDTH(DW)) bus ();

   fifo_bank4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .AF_THRESH(AF)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] dout [4];
   logic [3:0]    vout, empty, full, af;
   assign dout[0] = bus.data_out0;
   assign dout[1] = bus.data_out1;
   assign dout[2] = bus.data_out2;
   assign dout[3] = bus.data_out3;
   assign vout  = {bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0};
   assign empty = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
   assign full  = {bus.full3, bus.full2, bus.full1, bus.full0};
   assign af    = {bus.almost_full3, bus.almost_full2, bus.almost_full1, bus.almost_full0};

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic [DW-1:0] model_q [4][$];
   exp_t          exp_q [4][$];
   logic          model_ovf = 1'b0;
   int            rst_gen = 0;
   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, ch, act, exp, $time);
      end
   endtask

   // One clock of stimulus: check flags against the model, drive inputs,
   // then advance the model to the state after the coming rising edge.
   task automatic cycle(input logic psh, input logic [DW-1:0] din, input logic [3:0] pops);
      int   d;
      int   sz;
      logic acc;
      logic any_af;
      exp_t e;
      @(negedge clk);
      any_af = 1'b0;
      for (int n = 0; n < 4; n++) begin
         sz = model_q[n].size();
         check("empty", n, 32'(empty[n]), 32'(sz == 0));
         check("full", n, 32'(full[n]), 32'(sz == DEPTH));
         check("almost_full", n, 32'(af[n]), 32'(sz >= AF));
         if (sz >= AF) any_af = 1'b1;
      end
      check("pause", 0, 32'(bus.pause), 32'(any_af));
      check("err", 0, 32'(bus.err), 32'(ERR_EN & model_ovf));

      bus.push    = psh;
      bus.data_in = din;
      bus.pop0    = pops[0];
      bus.pop1    = pops[1];
      bus.pop2    = pops[2];
      bus.pop3    = pops[3];

      d   = int'(din[DW-1 -: 2]);
      acc = psh && (model_q[d].size() < DEPTH);
      if (psh && !acc) model_ovf = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if (pops[n] && model_q[n].size() > 0) begin
            e.data = model_q[n].pop_front();
            e.due  = cyc + 1;
            exp_q[n].push_back(e);
         end
      end
      if (acc) model_q[d].push_back(din);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 4'b0000);
   endtask

   // Let outstanding reads retire, then pulse reset for one clock.
   task automatic do_reset();
      idle(2);
      @(negedge clk);
      bus.push = 1'b0;
      bus.pop0 = 1'b0;
      bus.pop1 = 1'b0;
      bus.pop2 = 1'b0;
      bus.pop3 = 1'b0;
      reset_L  = 1'b0;
      rst_gen++;
      for (int n = 0; n < 4; n++) model_q[n].delete();
      model_ovf = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   // Monitor: after every rising edge, match read-data pulses to expectations.
   initial begin
      int            seen_rst;
      logic [DW-1:0] last [4];
      exp_t          e;
      seen_rst = 0;
      for (int n = 0; n < 4; n++) last[n] = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (rst_gen != seen_rst) begin
            seen_rst = rst_gen;
            for (int n = 0; n < 4; n++) last[n] = '0;
         end
         for (int n = 0; n < 4; n++) begin
            if (vout[n]) begin
               if (exp_q[n].size() == 0 || exp_q[n][0].due != cyc) begin
                  check("valid_out", n, 32'(vout[n]), 32'd0);
               end else begin
                  e = exp_q[n].pop_front();
                  check("data_out", n, 32'(dout[n]), 32'(e.data));
                  last[n] = e.data;
               end
            end else begin
               if (exp_q[n].size() > 0 && exp_q[n][0].due == cyc) begin
                  check("valid_out", n, 32'(vout[n]), 32'd1);
                  e = exp_q[n].pop_front();
                  last[n] = e.data;
               end
               check("data_hold", n, 32'(dout[n]), 32'(last[n]));
            end
         end
      end
   end

   initial begin
      logic          psh;
      logic [DW-1:0] din;
      logic [3:0]    pops;
      int            pop_pct;
      bus.push    = 1'b0;
      bus.data_in = '0;
      bus.pop0    = 1'b0;
      bus.pop1    = 1'b0;
      bus.pop2    = 1'b0;
      bus.pop3    = 1'b0;
      repeat (2) @(negedge clk);
      reset_L = 1'b1;

      // reset state, idle
      idle(3);

      // one word per channel, popped together
      cycle(1'b1, 10'h005, 4'b0000);
      cycle(1'b1, 10'h10A, 4'b0000);
      cycle(1'b1, 10'h20F, 4'b0000);
      cycle(1'b1, 10'h3FF, 4'b0000);
      cycle(1'b0, '0, 4'b1111);
      idle(2);

      // fill channel 2 past full, then drain with one extra pop
      for (int i = 1; i <= 9; i++) cycle(1'b1, {2'b10, 8'(i)}, 4'b0000);
      for (int i = 1; i <= 9; i++) cycle(1'b0, '0, 4'b0100);
      idle(2);

      // channel 1 held at three words with push+pop across pointer wrap
      for (int i = 0; i < 3; i++) cycle(1'b1, {2'b01, 8'(8'h40 + i)}, 4'b0000);
      for (int i = 0; i < 10; i++) cycle(1'b1, {2'b01, 8'(8'h50 + i)}, 4'b0010);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 4'b0010);
      idle(2);

      // continuous pop on channel 0 with a single word arriving
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 4'b0001);
      cycle(1'b1, 10'h0AB, 4'b0001);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 4'b0001);
      idle(1);

      // channel 3 loaded, then reset drops everything
      for (int i = 0; i < 4; i++) cycle(1'b1, {2'b11, 8'(8'hC0 + i)}, 4'b0000);
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 4'b1000);
      idle(2);

      // randomized traffic with varying drain rate
      for (int ph = 0; ph < 6; ph++) begin
         pop_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 40 : 75);
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            psh = ($urandom_range(0, 99) < 65);
            din = DW'($urandom);
            if ($urandom_range(0, 2) == 0) din[DW-1 -: 2] = 2'(ph % 4);
            for (int n = 0; n < 4; n++) pops[n] = ($urandom_range(0, 99) < pop_pct);
            cycle(psh, din, pops);
         end
      end
      idle(3);

      for (int n = 0; n < 4; n++) check("pending_reads", n, 32'(exp_q[n].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
